fetch_controller: RTL and testbench

//  Instruction fetch/sequence FSM that drives the ProgramCounter (inc_pc, load_pc, pc_val).

---
 rtl/fetch_controller_pkg.sv | 32 +++
 rtl/fetch_controller_if.sv | 33 +++
 rtl/fetch_controller_branch_resolve.sv | 23 ++
 rtl/fetch_controller.sv | 115 +++++++++++
 tb/tb_fetch_controller.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction fetch/sequence controller:
// opcode values, sequencer state encoding and the branch-resolution result.
package fetch_controller_pkg;

  // Opcodes resolved locally by the controller; every other opcode goes to the datapath.
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_JZ  = 4'hB;
  localparam logic [3:0] OP_JNZ = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } fc_state_e;

  // Decode classification. Exactly one field is set, except for a
  // conditional jump that is not taken, where all three are clear.
  typedef struct packed {
    logic take_jump;
    logic is_halt;
    logic is_exec;
  } br_res_t;

  // True for the two flag-dependent jump opcodes.
  function automatic logic is_cond_jump(input logic [3:0] op);
    return (op == OP_JZ) || (op == OP_JNZ);
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Instruction-memory read channel and execute handshake between the
// fetch controller (master) and the memory/datapath side (slave).
interface fetch_controller_if #(
  parameter int WIDTH   = 11,
  parameter int IR_BITS = 16
);

  logic               mem_req;
  logic [WIDTH:0]     mem_addr;
  logic               mem_ack;
  logic [IR_BITS-1:0] mem_rdata;
  logic               exec_valid;
  logic               exec_done;

  modport master (
    output mem_req,
    output mem_addr,
    output exec_valid,
    input  mem_ack,
    input  mem_rdata,
    input  exec_done
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  exec_valid,
    output mem_ack,
    output mem_rdata,
    output exec_done
  );

endinterface

// File: rtl/fetch_controller_branch_resolve.sv
// Combinational opcode classifier: decides whether the instruction in ir is
// a taken jump, a halt, or an instruction for the datapath.
module fetch_controller_branch_resolve
  import fetch_controller_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       zero_flag,
  output br_res_t    res
);

  // Classify the opcode; a conditional jump whose condition fails leaves all fields clear.
  always_comb begin
    res = '0;
    unique case (opcode)
      OP_JMP:  res.take_jump = 1'b1;
      OP_JZ:   res.take_jump = zero_flag;
      OP_JNZ:  res.take_jump = ~zero_flag;
      OP_HLT:  res.is_halt   = 1'b1;
      default: res.is_exec   = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch/sequence controller. Fetches the word at pc over the
// req/ack channel, latches it into ir, resolves jumps and halts itself and
// hands every other instruction to the datapath over exec_valid/exec_done.
// PC changes are requested from the external ProgramCounter with one-cycle
// inc_pc / load_pc pulses issued in DECODE, so the following FETCH already
// presents the updated address.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int WIDTH   = 11,
  parameter int IR_BITS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [WIDTH:0]     pc,
  output logic               inc_pc,
  output logic               load_pc,
  output logic [WIDTH:0]     pc_val,
  input  logic               zero_flag,
  output logic [IR_BITS-1:0] ir,
  output logic               halted,
  fetch_controller_if.master bus
);

  fc_state_e state;
  br_res_t   br;
  logic      in_decode;
  logic      cond_not_taken;

  fetch_controller_branch_resolve u_branch_resolve (
    .opcode    (ir[IR_BITS-1 -: 4]),
    .zero_flag (zero_flag),
    .res       (br)
  );

  assign in_decode      = (state == S_DECODE);
  assign cond_not_taken = is_cond_jump(ir[IR_BITS-1 -: 4]) & ~br.take_jump;

  // Sequencer: state, instruction register and the level outputs (mem_req,
  // exec_valid, halted) are all updated together on each transition.
  // Acks and dones arriving in any other state are simply not looked at.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      ir             <= '0;
      bus.mem_req    <= 1'b0;
      bus.exec_valid <= 1'b0;
      halted         <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (run) begin
            state       <= S_FETCH;
            bus.mem_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (bus.mem_ack) begin
            ir          <= bus.mem_rdata;
            state       <= S_DECODE;
            bus.mem_req <= 1'b0;
          end
        end
        S_DECODE: begin
          // Always a single cycle; run is not consulted here so a started
          // instruction (or the fetch after a jump) always completes.
          if (br.is_halt) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (br.is_exec) begin
            state          <= S_EXEC;
            bus.exec_valid <= 1'b1;
          end else begin
            state       <= S_FETCH;
            bus.mem_req <= 1'b1;
          end
        end
        S_EXEC: begin
          if (bus.exec_done) begin
            bus.exec_valid <= 1'b0;
            if (run) begin
              state       <= S_FETCH;
              bus.mem_req <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_HALT: begin
          // Resuming needs run to drop first, so a held run cannot spin on HLT.
          if (!run) begin
            state  <= S_IDLE;
            halted <= 1'b0;
          end
        end
        default: begin
          state          <= S_IDLE;
          bus.mem_req    <= 1'b0;
          bus.exec_valid <= 1'b0;
          halted         <= 1'b0;
        end
      endcase
    end
  end

  // PC update pulses from DECODE; the jump operand is only driven while load_pc is high.
  always_comb begin
    load_pc      = in_decode & br.take_jump;
    inc_pc       = in_decode & (br.is_exec | cond_not_taken);
    pc_val       = load_pc ? ir[WIDTH:0] : '0;
    bus.mem_addr = bus.mem_req ? pc : '0;
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a ProgramCounter model, a
// behavioural instruction memory with programmable ack latency and a
// datapath model that pulses exec_done a fixed number of cycles later.
module tb_fetch_controller;
  import fetch_controller_pkg::*;

  localparam int W_IDLE  = 0;
  localparam int W_HALT  = 1;
  localparam int W_ACK   = 2;
  localparam int W_FETCH = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [11:0] pc;
  logic [11:0] pc_init;
  logic        inc_pc;
  logic        load_pc;
  logic [11:0] pc_val;
  logic        zero_flag;
  logic [15:0] ir;
  logic        halted;

  logic [15:0] mem [0:4095];
  int          mem_lat;
  int          exe_lat;
  int          m_cnt;
  int          e_cnt;
  logic        resp_ack;
  logic [15:0] resp_data;
  logic        resp_done;
  logic        man_ack;
  logic [15:0] man_data;

  logic        clr_mon;
  int          inc_cnt, load_cnt, both_cnt, exec_win, req_cyc, exv_cyc;
  int          inc_run, inc_max, last_pv;
  logic        req_prev, ev_prev;
  int          flog[$];

  int          n_vec = 0;
  int          n_err = 0;

  fetch_controller_if #(.WIDTH(11), .IR_BITS(16)) bus ();

  fetch_controller #(.WIDTH(11), .IR_BITS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .pc        (pc),
    .inc_pc    (inc_pc),
    .load_pc   (load_pc),
    .pc_val    (pc_val),
    .zero_flag (zero_flag),
    .ir        (ir),
    .halted    (halted),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.mem_ack   = resp_ack | man_ack;
  assign bus.mem_rdata = man_ack ? man_data : resp_data;
  assign bus.exec_done = resp_done;

  // ProgramCounter model: 12-bit register, wraps naturally
  always @(posedge clk or negedge rst) begin
    if (!rst)         pc <= pc_init;
    else if (load_pc) pc <= pc_val;
    else if (inc_pc)  pc <= pc + 12'd1;
  end

  // Instruction memory: ack mem_lat cycles after the first request cycle
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt     <= 0;
      resp_ack  <= 1'b0;
      resp_data <= '0;
    end else begin
      resp_ack <= 1'b0;
      if (bus.mem_req && !bus.mem_ack) begin
        if (m_cnt + 1 >= mem_lat) begin
          resp_ack  <= 1'b1;
          resp_data <= mem[bus.mem_addr];
          m_cnt     <= 0;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  // Datapath: exec_done exe_lat cycles after exec_valid rises
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_cnt     <= 0;
      resp_done <= 1'b0;
    end else begin
      resp_done <= 1'b0;
      if (bus.exec_valid && !bus.exec_done) begin
        if (e_cnt + 1 >= exe_lat) begin
          resp_done <= 1'b1;
          e_cnt     <= 0;
        end else begin
          e_cnt <= e_cnt + 1;
        end
      end
    end
  end

  // Event monitor sampled on the falling edge
  always @(negedge clk) begin
    if (clr_mon) begin
      inc_cnt  <= 0;
      load_cnt <= 0;
      both_cnt <= 0;
      exec_win <= 0;
      req_cyc  <= 0;
      exv_cyc  <= 0;
      inc_run  <= 0;
      inc_max  <= 0;
      last_pv  <= -1;
      req_prev <= 1'b0;
      ev_prev  <= 1'b0;
      flog.delete();
    end else begin
      if (inc_pc) begin
        inc_cnt <= inc_cnt + 1;
        inc_run <= inc_run + 1;
        if (inc_run + 1 > inc_max) inc_max <= inc_run + 1;
      end else begin
        inc_run <= 0;
      end
      if (load_pc) begin
        load_cnt <= load_cnt + 1;
        last_pv  <= int'(pc_val);
      end
      if (inc_pc && load_pc) both_cnt <= both_cnt + 1;
      if (bus.mem_req) req_cyc <= req_cyc + 1;
      if (bus.exec_valid) exv_cyc <= exv_cyc + 1;
      if (bus.exec_valid && !ev_prev) exec_win <= exec_win + 1;
      if (bus.mem_req && !req_prev) flog.push_back(int'(bus.mem_addr));
      req_prev <= bus.mem_req;
      ev_prev  <= bus.exec_valid;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int fl(input int i);
    return (i < flog.size()) ? flog[i] : -1;
  endfunction

  task automatic wait_until(input int kind, input int n, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      case (kind)
        W_IDLE:  hit = (dut.state == S_IDLE);
        W_HALT:  hit = halted;
        W_ACK:   hit = bus.mem_ack;
        W_FETCH: hit = bus.mem_req && (flog.size() == n);
        default: hit = 1'b0;
      endcase
      if (hit) break;
      tick();
    end
    chk(tag, 64'(hit), 64'(1));
  endtask

  task automatic do_reset(input logic [11:0] p0);
    run     = 1'b0;
    rst     = 1'b0;
    pc_init = p0;
    clr_mon = 1'b1;
    tick();
    tick();
    rst     = 1'b1;
    clr_mon = 1'b0;
    tick();
  endtask

  // One conditional jump at address 5; run drops during its fetch, so the
  // branch target is still fetched and executed before stopping.
  task automatic run_branch(input string tag, input logic [15:0] word, input logic zf,
                            input int exp_tgt, input int exp_taken);
    do_reset(12'd5);
    mem[5]    = word;
    zero_flag = zf;
    run       = 1'b1;
    wait_until(W_ACK, 0, {tag, "_ack"});
    run = 1'b0;
    wait_until(W_IDLE, 0, {tag, "_idle"});
    chk({tag, "_nfetch"}, 64'(flog.size()), 64'(2));
    chk({tag, "_tgt"},    64'(fl(1)),       64'(exp_tgt));
    chk({tag, "_pc"},     64'(pc),          64'(exp_tgt + 1));
    chk({tag, "_load"},   64'(load_cnt),    64'(exp_taken));
    chk({tag, "_inc"},    64'(inc_cnt),     64'(2 - exp_taken));
    chk({tag, "_both"},   64'(both_cnt),    64'(0));
  endtask

  initial begin
    rst       = 1'b0;
    run       = 1'b0;
    zero_flag = 1'b0;
    man_ack   = 1'b0;
    man_data  = '0;
    pc_init   = '0;
    clr_mon   = 1'b1;
    mem_lat   = 2;
    exe_lat   = 3;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;

    // ---- Linear: three exec words, run drops during the third fetch
    do_reset(12'd0);
    mem[0] = 16'h1000;
    mem[1] = 16'h2000;
    mem[2] = 16'h3000;
    chk("rst_state", 64'(dut.state == S_IDLE), 64'(1));
    chk("rst_outs", 64'({inc_pc, load_pc, pc_val, bus.mem_req, bus.mem_addr,
                         bus.exec_valid, ir, halted}), 64'(0));
    run = 1'b1;
    wait_until(W_FETCH, 3, "lin_f3");
    chk("lin_addr2", 64'(bus.mem_addr), 64'(2));
    run = 1'b0;
    wait_until(W_IDLE, 0, "lin_idle");
    chk("lin_pc",     64'(pc),       64'(3));
    chk("lin_win",    64'(exec_win), 64'(3));
    chk("lin_inc",    64'(inc_cnt),  64'(3));
    chk("lin_incmax", 64'(inc_max),  64'(1));
    chk("lin_load",   64'(load_cnt), 64'(0));
    chk("lin_reqcyc", 64'(req_cyc),  64'(9));
    chk("lin_exvcyc", 64'(exv_cyc),  64'(12));
    chk("lin_flog",   64'({fl(0), fl(1), fl(2)}), 64'({32'sd0, 32'sd1, 32'sd2}));
    chk("lin_ir",     64'(ir),       64'(16'h3000));

    // ---- Reset mid-FETCH, then a stray ack in IDLE
    mem_lat = 10;
    run     = 1'b1;
    tick();
    chk("rmid_req",  64'(bus.mem_req),  64'(1));
    chk("rmid_addr", 64'(bus.mem_addr), 64'(3));
    rst = 1'b0;
    #1;
    chk("rmid_outs", 64'({inc_pc, load_pc, pc_val, bus.mem_req, bus.mem_addr,
                          bus.exec_valid, ir, halted}), 64'(0));
    chk("rmid_state", 64'(dut.state == S_IDLE), 64'(1));
    run = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    man_data = 16'hA123;
    man_ack  = 1'b1;
    tick();
    man_ack = 1'b0;
    tick();
    chk("late_ack_ir",    64'(ir), 64'(0));
    chk("late_ack_state", 64'(dut.state == S_IDLE), 64'(1));
    chk("late_ack_req",   64'(bus.mem_req), 64'(0));
    mem_lat = 2;

    // ---- JMP 0x105 from address 0
    do_reset(12'd0);
    mem[0]   = 16'hA105;
    mem[261] = 16'h1234;
    run = 1'b1;
    wait_until(W_FETCH, 2, "jmp_f2");
    chk("jmp_addr", 64'(bus.mem_addr), 64'(261));
    chk("jmp_pv",   64'(last_pv),      64'(261));
    chk("jmp_load", 64'(load_cnt),     64'(1));
    chk("jmp_noinc", 64'(inc_cnt),     64'(0));
    run = 1'b0;
    wait_until(W_IDLE, 0, "jmp_idle");
    chk("jmp_pc",  64'(pc),       64'(262));
    chk("jmp_win", 64'(exec_win), 64'(1));
    chk("jmp_ir",  64'(ir),       64'(16'h1234));

    // ---- Conditional jumps to 0x020 from address 5
    run_branch("jz0",  16'hB020, 1'b0, 6,  0);
    run_branch("jz1",  16'hB020, 1'b1, 32, 1);
    run_branch("jnz1", 16'hC020, 1'b1, 6,  0);
    run_branch("jnz0", 16'hC020, 1'b0, 32, 1);
    zero_flag = 1'b0;

    // ---- HLT at 7: stays halted while run holds, refetches after run toggles
    do_reset(12'd7);
    mem[7] = 16'hF000;
    run = 1'b1;
    wait_until(W_HALT, 0, "hlt_wait");
    chk("hlt_pc",   64'(pc), 64'(7));
    chk("hlt_pcop", 64'(inc_cnt + load_cnt), 64'(0));
    tick();
    tick();
    tick();
    chk("hlt_hold", 64'({halted, bus.mem_req, bus.exec_valid}), 64'(3'b100));
    chk("hlt_nfetch", 64'(flog.size()), 64'(1));
    run = 1'b0;
    tick();
    chk("hlt_exit", 64'(halted), 64'(0));
    chk("hlt_idle", 64'(dut.state == S_IDLE), 64'(1));
    run = 1'b1;
    wait_until(W_HALT, 0, "hlt_again");
    chk("hlt_refetch", 64'({fl(0), fl(1)}), 64'({32'sd7, 32'sd7}));
    chk("hlt_pc2", 64'(pc), 64'(7));
    run = 1'b0;
    tick();

    // ---- Wrap: JMP 0xFFF, exec at 4095, next fetch at 0
    do_reset(12'd0);
    mem[0]    = 16'hAFFF;
    mem[4095] = 16'h1000;
    run = 1'b1;
    wait_until(W_FETCH, 3, "wrap_f3");
    chk("wrap_addr", 64'(bus.mem_addr), 64'(0));
    chk("wrap_pc",   64'(pc),           64'(0));
    chk("wrap_pv",   64'(last_pv),      64'(4095));
    chk("wrap_f1",   64'(fl(1)),        64'(4095));
    run = 1'b0;
    wait_until(W_IDLE, 0, "wrap_idle");
    chk("wrap_pc2",  64'(pc),       64'(0));
    chk("wrap_win",  64'(exec_win), 64'(2));
    chk("wrap_both", 64'(both_cnt), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
